spi_slave_tx_arbiter: RTL and testbench

Shares the transmit path of one SPI slave endpoint among `NUM_REQ` on-chip requesters and buffers the endpoint's received words for a single consumer. It has three jobs:
- Grant the transmit slot round-robin.
- Present exactly one word on the slave's `data_in` while the SPI bus is idle.
- Report which requester's word was shifted out.

It sits between the requesters and the `spi_slave` instance, in the `sclk` domain.

---
 rtl/spi_slave_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_spi_slave_tx_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_tx_arbiter.sv
// spi_slave_tx_arbiter: round-robin share of one SPI slave's transmit word among
// NUM_REQ requesters, plus a one-entry holding register for received words.
module spi_slave_tx_arbiter #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           NUM_REQ    = 4,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '1
) (
    input  logic                          sclk,
    input  logic                          rst_n,
    input  logic                          ss_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            tx_done,
    input  logic                          tx_flush,
    output logic [NUM_REQ-1:0]            tx_drop,
    output logic [DATA_WIDTH-1:0]         slv_data_in,
    input  logic                          slv_send_ready,
    input  logic [DATA_WIDTH-1:0]         slv_data_out,
    input  logic                          slv_data_valid,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_overrun,
    input  logic                          ovr_clr
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        owner_q, owner_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]   tx_word_q, tx_word_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [NUM_REQ-1:0]      drop_q, drop_d;
    logic                    gnt_found;
    logic [PTR_W-1:0]        gnt_idx;
    logic                    ovr_set;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(idx);
            end
        end
    end

    // TX state register and pulse outputs.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            tx_word_q <= '0;
            done_q    <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            tx_word_q <= tx_word_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
        end
    end

    // TX next-state: grant only while the bus is idle; leave LOADED on send or flush.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        tx_word_d = tx_word_q;
        done_d    = '0;
        drop_d    = '0;
        req_ready = '0;
        case (state_q)
            EMPTY: begin
                if (ss_n && gnt_found && rst_n) begin
                    req_ready[gnt_idx] = 1'b1;
                    state_d            = LOADED;
                    owner_d            = gnt_idx;
                    tx_word_d          = req_data[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                    rr_ptr_d           = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                end
            end
            LOADED: begin
                if (slv_send_ready) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = EMPTY;
                end else if (tx_flush && ss_n) begin
                    drop_d[owner_q] = 1'b1;
                    state_d         = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign slv_data_in = (state_q == LOADED) ? tx_word_q : FILL_WORD;
    assign tx_done     = done_q;
    assign tx_drop     = drop_q;

    assign ovr_set = slv_data_valid && rx_valid && !rx_ready;

    // RX holding register; a word arriving while the old one is still held is lost.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (slv_data_valid) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= slv_data_out;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            rx_overrun <= ovr_set || (rx_overrun && !ovr_clr);
        end
    end

endmodule

// File: tb/tb_spi_slave_tx_arbiter.sv
// Bench for spi_slave_tx_arbiter: directed vector table, RX/reset sequences,
// and randomized traffic against a behavioural model.
module tb_spi_slave_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic              sclk = 1'b0;
    logic              rst_n;
    logic              ss_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   tx_done;
    logic              tx_flush;
    logic [NREQ-1:0]   tx_drop;
    logic [DW-1:0]     slv_data_in;
    logic              slv_send_ready;
    logic [DW-1:0]     slv_data_out;
    logic              slv_data_valid;
    logic [DW-1:0]     rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              rx_overrun;
    logic              ovr_clr;

    int n_chk  = 0;
    int n_fail = 0;

    spi_slave_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NREQ), .FILL_WORD(8'hFF)) dut (
        .sclk(sclk), .rst_n(rst_n), .ss_n(ss_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .tx_done(tx_done), .tx_flush(tx_flush), .tx_drop(tx_drop),
        .slv_data_in(slv_data_in), .slv_send_ready(slv_send_ready),
        .slv_data_out(slv_data_out), .slv_data_valid(slv_data_valid),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .ovr_clr(ovr_clr)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic            ss;
        logic [NREQ-1:0] v;
        logic            sr;
        logic            fl;
        logic [NREQ-1:0] ready;
        logic [DW-1:0]   din;
        logic [NREQ-1:0] done;
        logic [NREQ-1:0] drop;
    } vec_t;

    vec_t tbl[28];

    // behavioural model state
    bit            m_loaded;
    int            m_owner, m_ptr;
    logic [DW-1:0] m_word;
    logic [NREQ-1:0] m_done, m_drop;
    bit            m_rxv, m_ovr;
    logic [DW-1:0] m_rxd;

    function automatic int m_grant();
        if (m_loaded || !ss_n || req_valid == '0) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    initial begin
        logic [NREQ-1:0] exp_ready;
        int g;
        rst_n = 1'b0; ss_n = 1'b1; req_valid = '0; tx_flush = 1'b0;
        slv_send_ready = 1'b0; slv_data_out = '0; slv_data_valid = 1'b0;
        rx_ready = 1'b0; ovr_clr = 1'b0;
        req_data = {8'hC3, 8'h3C, 8'h5A, 8'hA5};

        //            ss  valid   sr  fl  ready    din    done     drop
        tbl[0]  = '{1'b1, 4'b0101, 1'b0, 1'b0, 4'b0001, 8'hFF, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 8'hA5, 4'b0000, 4'b0000};
        tbl[2]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 8'hA5, 4'b0000, 4'b0000};
        tbl[3]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 4'b0100, 8'hFF, 4'b0001, 4'b0000};
        tbl[4]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h3C, 4'b0000, 4'b0000};
        tbl[5]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 8'h3C, 4'b0000, 4'b0000};
        tbl[6]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'hFF, 4'b0100, 4'b0000};
        tbl[7]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 8'hFF, 4'b0000, 4'b0000};
        tbl[8]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 8'hFF, 4'b0000, 4'b0000};
        tbl[9]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 4'b0010, 8'hFF, 4'b0000, 4'b0000};
        tbl[10] = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 8'h5A, 4'b0000, 4'b0000};
        tbl[11] = '{1'b1, 4'b1000, 1'b0, 1'b0, 4'b1000, 8'hFF, 4'b0000, 4'b0010};
        tbl[12] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 8'hC3, 4'b0000, 4'b0000};
        tbl[13] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 8'hC3, 4'b0000, 4'b0000};
        tbl[14] = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 8'hC3, 4'b0000, 4'b0000};
        tbl[15] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'hFF, 4'b0000, 4'b1000};
        tbl[16] = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 8'hFF, 4'b0000, 4'b0000};
        tbl[17] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'hFF, 4'b0000, 4'b0000};
        tbl[18] = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 8'hFF, 4'b0000, 4'b0000};
        tbl[19] = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 8'hA5, 4'b0000, 4'b0000};
        tbl[20] = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0010, 8'hFF, 4'b0001, 4'b0000};
        tbl[21] = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 8'h5A, 4'b0000, 4'b0000};
        tbl[22] = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0100, 8'hFF, 4'b0010, 4'b0000};
        tbl[23] = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 8'h3C, 4'b0000, 4'b0000};
        tbl[24] = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b1000, 8'hFF, 4'b0100, 4'b0000};
        tbl[25] = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 8'hC3, 4'b0000, 4'b0000};
        tbl[26] = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 8'hFF, 4'b1000, 4'b0000};
        tbl[27] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'hA5, 4'b0000, 4'b0000};

        // reset values
        @(negedge sclk); #1;
        chk("rst_din", 32'(slv_data_in), 32'hFF);
        chk("rst_rxv", 32'(rx_valid), 32'h0);
        chk("rst_done", 32'(tx_done), 32'h0);
        @(negedge sclk); rst_n = 1'b1;

        // directed TX vectors
        for (int i = 0; i < 28; i++) begin
            @(negedge sclk);
            ss_n = tbl[i].ss; req_valid = tbl[i].v;
            slv_send_ready = tbl[i].sr; tx_flush = tbl[i].fl;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].ready));
            chk($sformatf("v%0d_din", i), 32'(slv_data_in), 32'(tbl[i].din));
            chk($sformatf("v%0d_done", i), 32'(tx_done), 32'(tbl[i].done));
            chk($sformatf("v%0d_drop", i), 32'(tx_drop), 32'(tbl[i].drop));
        end
        req_valid = '0; slv_send_ready = 1'b0; tx_flush = 1'b0;

        // RX overrun / simultaneous accept / clear-vs-set
        @(negedge sclk); slv_data_valid = 1'b1; slv_data_out = 8'h11; rx_ready = 1'b0;
        @(negedge sclk); slv_data_out = 8'h22; #1;
        chk("rx1_data", 32'(rx_data), 32'h11);
        chk("rx1_valid", 32'(rx_valid), 32'h1);
        chk("rx1_ovr", 32'(rx_overrun), 32'h0);
        @(negedge sclk); slv_data_out = 8'h33; rx_ready = 1'b1; #1;
        chk("rx2_data", 32'(rx_data), 32'h11);
        chk("rx2_ovr", 32'(rx_overrun), 32'h1);
        @(negedge sclk); slv_data_valid = 1'b0; rx_ready = 1'b0; #1;
        chk("rx3_data", 32'(rx_data), 32'h33);
        chk("rx3_valid", 32'(rx_valid), 32'h1);
        @(negedge sclk); ovr_clr = 1'b1; #1;
        @(negedge sclk); slv_data_valid = 1'b1; slv_data_out = 8'h44; #1;
        chk("rx_clr", 32'(rx_overrun), 32'h0);
        @(negedge sclk); slv_data_valid = 1'b0; ovr_clr = 1'b0; #1;
        chk("rx_setwins", 32'(rx_overrun), 32'h1);
        chk("rx_keep", 32'(rx_data), 32'h33);
        @(negedge sclk); rx_ready = 1'b1;
        @(negedge sclk); rx_ready = 1'b0; #1;
        chk("rx_drain", 32'(rx_valid), 32'h0);

        // asynchronous reset while LOADED (owner 0, word A5)
        ss_n = 1'b1; req_valid = 4'b1111;
        @(posedge sclk); #2; rst_n = 1'b0; #1;
        chk("arst_din", 32'(slv_data_in), 32'hFF);
        chk("arst_ready", 32'(req_ready), 32'h0);
        chk("arst_done", 32'(tx_done), 32'h0);
        chk("arst_drop", 32'(tx_drop), 32'h0);
        chk("arst_ovr", 32'(rx_overrun), 32'h0);
        chk("arst_rxd", 32'(rx_data), 32'h0);
        req_valid = '0;
        @(negedge sclk); rst_n = 1'b1; slv_send_ready = 1'b1;
        @(negedge sclk); slv_send_ready = 1'b0; #1;
        chk("post_rst_done", 32'(tx_done), 32'h0);
        chk("post_rst_drop", 32'(tx_drop), 32'h0);
        @(negedge sclk); #1;
        chk("post_rst_done2", 32'(tx_done), 32'h0);

        // randomized traffic against the model
        m_loaded = 0; m_owner = 0; m_ptr = 0; m_word = '0;
        m_done = '0; m_drop = '0; m_rxv = 0; m_ovr = 0; m_rxd = '0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge sclk);
            ss_n           = ($urandom_range(9) < 7);
            req_valid      = NREQ'($urandom);
            req_data       = $urandom;
            slv_send_ready = ($urandom_range(9) < 2);
            tx_flush       = ($urandom_range(9) < 1);
            slv_data_valid = ($urandom_range(9) < 4);
            slv_data_out   = DW'($urandom);
            rx_ready       = ($urandom_range(1) == 1);
            ovr_clr        = ($urandom_range(9) < 1);
            #1;
            g = m_grant();
            exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
            chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
            chk("rnd_din", 32'(slv_data_in), m_loaded ? 32'(m_word) : 32'hFF);
            chk("rnd_done", 32'(tx_done), 32'(m_done));
            chk("rnd_drop", 32'(tx_drop), 32'(m_drop));
            chk("rnd_rxv", 32'(rx_valid), 32'(m_rxv));
            chk("rnd_rxd", 32'(rx_data), 32'(m_rxd));
            chk("rnd_ovr", 32'(rx_overrun), 32'(m_ovr));
            // advance model across the coming edge
            m_done = '0; m_drop = '0;
            if (!m_loaded) begin
                if (g >= 0) begin
                    m_loaded = 1; m_owner = g;
                    m_word = req_data[g*DW +: DW];
                    m_ptr = (g + 1) % NREQ;
                end
            end else if (slv_send_ready) begin
                m_done = NREQ'(1 << m_owner); m_loaded = 0;
            end else if (tx_flush && ss_n) begin
                m_drop = NREQ'(1 << m_owner); m_loaded = 0;
            end
            if (slv_data_valid && m_rxv && !rx_ready) m_ovr = 1;
            else if (ovr_clr) m_ovr = 0;
            if (slv_data_valid) begin
                if (!m_rxv || rx_ready) begin m_rxd = slv_data_out; m_rxv = 1; end
            end else if (m_rxv && rx_ready) begin
                m_rxv = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
